stack_arbiter: RTL
==================

# stack_arbiter

Shares one `shift_register` bit-stack between `NUM_REQ` requesters.
- Arbitrates push/pop requests round-robin and drives the stack's `push`/`pop`/`wr_en`/`wr_data` controls.
- Tracks occupancy, rejects overflow and underflow with an error response, and sequences a multi-cycle flush.
- Instantiated next to the stack; both share `clk` and `reset`.

## Interface
- `N`, 5, stack depth; must match the stack instance.
- `NUM_REQ`, 4, number of requesters (≥2).
- `IDW`, `$clog2(NUM_REQ)`, requester-id width.

- `clk` in 1: single clock; everything on its rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in NUM_REQ: per-requester request.
- `req_op` in NUM_REQ: per-requester op; 1 = push, 0 = pop.
- `req_data` in NUM_REQ: per-requester push bit.
- `req_ready` out NUM_REQ: one-hot grant; transfer occurs when `req_valid[i] & req_ready[i]`.
- `flush` in 1: single-cycle flush request.
- `flush_busy` out 1: high while in the FLUSH state.
- `resp_valid` out 1: response strobe, one cycle per granted request.
- `resp_id` out IDW: id of the granted requester.
- `resp_data` out 1: popped bit; 0 for push or error.
- `resp_err` out 1: 1 = push when full or pop when empty.
- `stk_push`, `stk_pop`, `stk_wr_en`, `stk_wr_data` out 1 each: to the stack.
- `stk_out` in N: stack contents; bit 0 is top.
- `depth` out `$clog2(N+1)`: occupancy, 0..N.
- `full`, `empty` out 1: `depth==N` and `depth==0`.

## Operation
FSM states:
- **IDLE**
  - `flush` high and `depth!=0`: no grant this cycle; go to FLUSH.
  - `flush` high and `depth==0`: no grant; stay IDLE; no other effect.
  - Otherwise: grant at most one valid requester.
- **FLUSH**
  - Each cycle: `stk_pop=1`, `depth` decrements.
  - Exit to IDLE on the cycle the pop brings `depth` to 0.
  - `req_ready` is all-zero; `flush` is ignored.

Arbitration:
- Round-robin with pointer `last`; search order is `last+1`, `last+2`, … modulo NUM_REQ.
- `last` updates only on a grant.
- `last` resets to `NUM_REQ-1`, so requester 0 wins first.
- Grant is independent of `req_op` and of full/empty; errored requests still consume a grant.

Granted push, `depth<N`:
- `stk_push=1`, `stk_wr_en=1`, `stk_wr_data=req_data[g]`.
- `depth+1`.

Granted push, `depth==N`:
- No stack controls asserted; depth unchanged; `resp_err=1`.

Granted pop, `depth>0`:
- `stk_pop=1`; `resp_data` takes `stk_out[0]` from the grant cycle.
- `depth-1`.

Granted pop, `depth==0`:
- No stack controls; `resp_err=1`, `resp_data=0`.

Other rules:
- `stk_push` and `stk_pop` are never high together.
- `stk_wr_en` is high only with `stk_push`.
- `depth` arithmetic never wraps; overflow and underflow are blocked by the rules above.

## Timing
- Stack controls and `req_ready` are combinational from the current state and inputs; the stack updates at the same edge the grant transfers.
- Response is registered: `resp_valid` / `resp_id` / `resp_data` / `resp_err` appear exactly 1 cycle after the grant, for one cycle.
- Throughput: one request per cycle; back-to-back grants allowed.
- Flush from `flush` pulse at depth D:
  - 1 blocked IDLE cycle, then D FLUSH cycles.
  - `flush_busy` high for exactly D cycles.
  - Grants resume on the following cycle.
- Reset values: FSM=IDLE, `last=NUM_REQ-1`, `depth=0`, `empty=1`, `full=0`, `flush_busy=0`, all resp outputs 0.
- Reset also forces `req_ready=0` and all `stk_*` outputs to 0 in the reset cycle.
- Reset mid-flush or mid-response aborts immediately; the stack is reset by the same `reset`.

## Structure
- Package `stack_pkg`:
  - op encoding constants `OP_PUSH=1'b1`, `OP_POP=1'b0`.
  - FSM state typedef `{ST_IDLE, ST_FLUSH}`.
- Sub-module `rr_arbiter`:
  - Parameter `NUM_REQ`.
  - Inputs: `req` vector and an `advance` strobe.
  - Outputs: one-hot `grant` and binary `grant_id`.
  - Holds the `last` pointer.
- Top level holds the FSM, depth counter, error logic and response registers.

## Test plan
1. Reset held 2 cycles → `depth=0`, `empty=1`, `full=0`, `resp_valid=0`, `req_ready=0`, all `stk_*=0`.
2. Requester 0 pushes 1,0,1 → `stk_out[2:0]=3'b101`, `depth=3`. Three pops → `resp_data` 1,0,1 with `resp_err=0`, `depth=0`.
3. All four requesters hold `req_valid` (pushes) from reset → grants 0,1,2,3,0. After 5 pushes `full=1`; the next granted push gives `resp_err=1` and `stk_push=0`.
4. Pop at `depth=0` → `resp_err=1`, `resp_data=0`, `stk_pop=0`, `depth` stays 0. Push then pop back-to-back at `depth=0` → both succeed and `depth` returns to 0.
5. `flush` at `depth=3` with requests pending → 1 blocked cycle, then `flush_busy=1` and `stk_pop=1` for 3 cycles with `req_ready=0`. Then `depth=0`, and the next grant resumes round-robin order.
6. `reset` asserted in the 2nd FLUSH cycle → next cycle IDLE, `flush_busy=0`, `depth=0`, `resp_valid=0`.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared op encoding and FSM state type for the stack arbiter slice.
// No latency or backpressure of its own; constants and types only.
package stack_pkg;

    localparam logic OP_PUSH = 1'b1;
    localparam logic OP_POP  = 1'b0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, searching from last+1 upward.
// Zero-latency grant; the pointer moves only when advance is strobed with a request present.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grant_id
);

    logic [IDW-1:0] last;
    logic [IDW-1:0] idx;
    logic           found;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDW'((int'(last) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = idx;
            end
        end
    end

    // After reset the pointer sits on the highest id so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (reset) begin
            last <= IDW'(NUM_REQ - 1);
        end else if (advance && found) begin
            last <= grant_id;
        end
    end

endmodule

// File: rtl/stack_arbiter.sv
// Shares one bit-stack between NUM_REQ requesters; controls are combinational, response 1 cycle after grant.
// Backpressure via one-hot req_ready: none during flush, the flush-request cycle, or reset.
module stack_arbiter
    import stack_pkg::*;
#(
    parameter int N       = 5,
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_op,
    input  logic [NUM_REQ-1:0]     req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic                   flush,
    output logic                   flush_busy,
    output logic                   resp_valid,
    output logic [IDW-1:0]         resp_id,
    output logic                   resp_data,
    output logic                   resp_err,
    output logic                   stk_push,
    output logic                   stk_pop,
    output logic                   stk_wr_en,
    output logic                   stk_wr_data,
    input  logic [N-1:0]           stk_out,
    output logic [$clog2(N+1)-1:0] depth,
    output logic                   full,
    output logic                   empty
);

    localparam int DW = $clog2(N + 1);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(N);
    localparam logic [DW-1:0] DEPTH_ONE = DW'(1);

    state_t               state;
    state_t               state_nxt;
    logic [DW-1:0]        depth_nxt;
    logic                 accept;
    logic [NUM_REQ-1:0]   arb_req;
    logic [NUM_REQ-1:0]   grant;
    logic [IDW-1:0]       grant_id;
    logic                 grant_any;
    logic                 grant_op;
    logic                 push_ok;
    logic                 pop_ok;
    logic                 unused_stk;

    // Only the top bit is ever read back; deeper entries are the stack's business.
    assign unused_stk = ^stk_out[N-1:1];

    assign accept  = (state == ST_IDLE) && !flush && !reset;
    assign arb_req = accept ? req_valid : '0;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_arb (
        .clk      (clk),
        .reset    (reset),
        .req      (arb_req),
        .advance  (grant_any),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign req_ready  = grant;
    assign grant_any  = |grant;
    assign grant_op   = req_op[grant_id];
    assign push_ok    = grant_any && (grant_op == OP_PUSH) && !full;
    assign pop_ok     = grant_any && (grant_op == OP_POP) && !empty;

    assign full       = (depth == DEPTH_MAX);
    assign empty      = (depth == '0);
    assign flush_busy = (state == ST_FLUSH);

    always_comb begin
        state_nxt   = state;
        depth_nxt   = depth;
        stk_push    = 1'b0;
        stk_pop     = 1'b0;
        stk_wr_en   = 1'b0;
        stk_wr_data = 1'b0;
        if (!reset) begin
            case (state)
                ST_IDLE: begin
                    if (flush) begin
                        if (!empty) state_nxt = ST_FLUSH;
                    end else if (push_ok) begin
                        stk_push    = 1'b1;
                        stk_wr_en   = 1'b1;
                        stk_wr_data = req_data[grant_id];
                        depth_nxt   = depth + 1'b1;
                    end else if (pop_ok) begin
                        stk_pop   = 1'b1;
                        depth_nxt = depth - 1'b1;
                    end
                end
                ST_FLUSH: begin
                    // Leave on the pop that empties the stack so grants resume next cycle.
                    if (!empty) begin
                        stk_pop   = 1'b1;
                        depth_nxt = depth - 1'b1;
                        if (depth == DEPTH_ONE) state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            depth      <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            depth      <= depth_nxt;
            resp_valid <= grant_any;
            resp_id    <= grant_id;
            resp_data  <= pop_ok & stk_out[0];
            resp_err   <= grant_any & !push_ok & !pop_ok;
        end
    end

    a_push_pop_excl: assert property (@(posedge clk) disable iff (reset) !(stk_push && stk_pop));
    a_wr_en_push:    assert property (@(posedge clk) disable iff (reset) stk_wr_en |-> stk_push);
    a_depth_bound:   assert property (@(posedge clk) disable iff (reset) depth <= DEPTH_MAX);
    a_grant_onehot:  assert property (@(posedge clk) disable iff (reset) $onehot0(req_ready));

endmodule
